// File: rtl/merge_ctrl_pkg.sv
// Shared types and constants for the two-input merge sequencing controller.
package merge_ctrl_pkg;

  localparam int unsigned DEFAULT_KEY_W = 32;
  localparam int unsigned DEFAULT_RUN_W = 16;

  // A head key equal to this value marks the end of a run.
  localparam int unsigned TERM_KEY = 0;

  typedef enum logic [2:0] {
    MERGE,
    DRAIN_A,
    DRAIN_B,
    FLUSH_A,
    FLUSH_B
  } merge_state_t;

endpackage

// File: rtl/merge_ctrl.sv
// Merge sequencing controller: picks which FIFO head the merger consumes, stalls on
// back-pressure or missing data, and counts completed runs and their lengths.
module merge_ctrl
  import merge_ctrl_pkg::*;
#(
  parameter int unsigned KEY_W = DEFAULT_KEY_W,
  parameter int unsigned RUN_W = DEFAULT_RUN_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_out_full,
  input  logic             i_a_empty,
  input  logic             i_b_empty,
  input  logic [KEY_W-1:0] i_a_key,
  input  logic [KEY_W-1:0] i_b_key,
  output logic             o_select_a,
  output logic             o_stall,
  output logic             o_switch_output,
  output logic             o_run_done,
  output logic [RUN_W-1:0] o_run_count,
  output logic [RUN_W-1:0] o_run_len
);

  merge_state_t     state_q, state_d;
  logic [RUN_W-1:0] len_q;
  logic [RUN_W-1:0] run_count_q;
  logic [RUN_W-1:0] run_len_q;
  logic             run_done_q;

  logic a_term, b_term;
  logic sel, adv;
  logic flush_done, count_en;

  assign a_term = (i_a_key == KEY_W'(TERM_KEY));
  assign b_term = (i_b_key == KEY_W'(TERM_KEY));

  always_comb begin
    state_d = state_q;
    sel     = 1'b1;
    adv     = 1'b0;
    case (state_q)
      MERGE: begin
        // A terminator never wins the compare while the other side still has data.
        if (a_term && !b_term) begin
          sel = 1'b0;
        end else if (b_term && !a_term) begin
          sel = 1'b1;
        end else begin
          sel = (i_a_key <= i_b_key);
        end
        adv = !i_out_full && !i_a_empty && !i_b_empty && !(a_term && b_term);
        if (!i_a_empty && !i_b_empty && a_term && b_term) begin
          state_d = FLUSH_A;
        end else if (adv && a_term) begin
          state_d = DRAIN_B;
        end else if (adv && b_term) begin
          state_d = DRAIN_A;
        end
      end
      DRAIN_A: begin
        sel = 1'b1;
        adv = !i_out_full && !i_a_empty && !a_term;
        if (!i_a_empty && a_term) begin
          state_d = FLUSH_A;
        end
      end
      DRAIN_B: begin
        sel = 1'b0;
        adv = !i_out_full && !i_b_empty && !b_term;
        // A's terminator is still at its head, so both terminators get flushed in order.
        if (!i_b_empty && b_term) begin
          state_d = FLUSH_A;
        end
      end
      FLUSH_A: begin
        sel = 1'b1;
        adv = !i_out_full && !i_a_empty;
        if (adv) begin
          state_d = FLUSH_B;
        end
      end
      FLUSH_B: begin
        sel = 1'b0;
        adv = !i_out_full && !i_b_empty;
        if (adv) begin
          state_d = MERGE;
        end
      end
      default: state_d = MERGE;
    endcase
  end

  assign flush_done = adv && (state_q == FLUSH_B);
  assign count_en   = adv && ((state_q == MERGE) || (state_q == DRAIN_A) || (state_q == DRAIN_B));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= MERGE;
      len_q       <= '0;
      run_count_q <= '0;
      run_len_q   <= '0;
      run_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_done_q <= flush_done;
      if (flush_done) begin
        run_count_q <= run_count_q + RUN_W'(1);
        run_len_q   <= len_q;
        len_q       <= '0;
      end else if (count_en && (len_q != '1)) begin
        len_q <= len_q + RUN_W'(1);
      end
    end
  end

  // Reset forces a safe hold regardless of the FIFO and key inputs.
  assign o_stall         = i_rst || !adv;
  assign o_select_a      = i_rst || sel;
  assign o_switch_output = !i_rst && flush_done;
  assign o_run_done      = run_done_q;
  assign o_run_count     = run_count_q;
  assign o_run_len       = run_len_q;

endmodule
